flow_sender: RTL and testbench

Upstream producer that feeds the four data FIFOs of the flow-controlled path and obeys the FIFO controller's flow-control outputs. It accepts words over a valid/ready handshake and steers each word to one lane by destination field. It stops a lane on `pausa`, resumes on `continuar`/`idle` or pause release, and halts permanently on `error_full`. A two-entry output/skid buffer absorbs the registered latency of the flow-control signals, so no accepted word is ever lost or duplicated.

---
 rtl/flow_pkg.sv | 30 +++
 rtl/skid_buf.sv | 79 +++++++
 rtl/flow_sender.sv | 123 ++++++++++++
 tb/tb_flow_sender.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_pkg.sv
// Shared constants for the flow-controlled FIFO path: sender and
// controller state encodings, lane count, default widths.
package flow_pkg;

  localparam int LANES      = 4;
  localparam int DEF_DATA_W = 6;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_SEND  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    FC_RESET  = 3'd0,
    FC_INIT   = 3'd1,
    FC_IDLE   = 3'd2,
    FC_ACTIVE = 3'd3,
    FC_ERROR  = 3'd4
  } fc_state_t;

  function automatic logic [LANES-1:0] lane_onehot(
    input logic [1:0] lane
  );
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry head + skid buffer, FIFO ordered.
// Ports: clk, rst (sync, high), enb (clock enable), accept_en (upstream
//   may be accepted), in_valid/in_data/in_dest/in_ready (source
//   handshake), pop (head leaves this cycle), head_valid/head_data/
//   head_dest (oldest word).
module skid_buf
  import flow_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic              accept_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  output logic              in_ready,
  input  logic              pop,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        head_dest
);

  logic              hv;
  logic              sv;
  logic [DATA_W-1:0] hdata;
  logic [DATA_W-1:0] sdata;
  logic [1:0]        hdest;
  logic [1:0]        sdest;
  logic              acc;
  logic              take;

  // Ready only depends on the skid slot, so a full head with an
  // empty skid still takes a word while the head is stalled.
  assign in_ready = enb & accept_en & ~sv;
  assign acc      = in_valid & in_ready;
  assign take     = enb & pop & hv;

  always_ff @(posedge clk) begin
    if (rst) begin
      hv <= 1'b0;
      sv <= 1'b0;
    end else if (enb) begin
      if (take) begin
        if (sv) begin
          hv <= 1'b1;
          sv <= 1'b0;
        end else begin
          hv <= acc;
        end
      end else if (acc) begin
        if (hv) sv <= 1'b1;
        else    hv <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enb) begin
      if (take & sv) begin
        hdata <= sdata;
        hdest <= sdest;
      end else if (acc & (~hv | take)) begin
        hdata <= in_data;
        hdest <= in_dest;
      end
      if (acc & hv & ~take) begin
        sdata <= in_data;
        sdest <= in_dest;
      end
    end
  end

  assign head_valid = hv;
  assign head_data  = hdata;
  assign head_dest  = hdest;

endmodule

// File: rtl/flow_sender.sv
// Upstream producer for the four flow-controlled data FIFOs.
// Ports: clk, rst (sync, high), enb; in_valid/in_data/in_dest/in_ready
//   source handshake; pausa/continuar/idle/error_full flow control;
//   push (one-hot strobe), push_data; state_o, halted; sent_cnt
//   (per-lane push counters, built only with FLOW_SENDER_STATS_EN).
module flow_sender
  import flow_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enb,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [1:0]         in_dest,
  output logic               in_ready,
  input  logic [3:0]         pausa,
  input  logic [3:0]         continuar,
  input  logic               idle,
  input  logic               error_full,
  output logic [3:0]         push,
  output logic [DATA_W-1:0]  push_data,
  output logic [1:0]         state_o,
  output logic               halted,
  output logic [4*CNT_W-1:0] sent_cnt
);

  state_t            state;
  logic [3:0]        pq;
  logic              hv;
  logic [DATA_W-1:0] hdata;
  logic [1:0]        hdest;
  logic              blocked;
  logic              live;
  logic              fire;
  logic              accept_en;

  // Only the registered pause is used; continuar/idle override it
  // combinationally so a release acts in the same cycle.
  assign blocked = pq[hdest] & ~continuar[hdest] & ~idle;
  assign live    = (state == ST_SEND) | (state == ST_HOLD);

  // error_full suppresses any push computed in its cycle.
  assign fire = enb & ~rst & live & hv & ~blocked & ~error_full;

  assign push      = fire ? lane_onehot(hdest) : 4'b0000;
  assign push_data = fire ? hdata : '0;

  // A word taken in RESET lands in the head and is pushed once SEND.
  assign accept_en = ~rst & (state != ST_HALT);
  assign state_o   = state;

  skid_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .accept_en (accept_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_ready  (in_ready),
    .pop       (fire),
    .head_valid(hv),
    .head_data (hdata),
    .head_dest (hdest)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RESET;
      halted <= 1'b0;
      pq     <= 4'b0000;
    end else if (enb) begin
      pq <= pausa;
      unique case (state)
        ST_RESET: begin
          if (error_full) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (error_full) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (hv & blocked) begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (error_full) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (~blocked) begin
            state <= ST_SEND;
          end
        end
        ST_HALT: ;
      endcase
    end
  end

`ifdef FLOW_SENDER_STATS_EN
  logic [CNT_W-1:0] cnt [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst)          cnt[i] <= '0;
      else if (push[i]) cnt[i] <= cnt[i] + CNT_W'(1);
    end
    assign sent_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`else
  assign sent_cnt = '0;
`endif

endmodule

// File: tb/tb_flow_sender.sv
// Self-checking bench for flow_sender: directed vector table, hand
// sequences (enable freeze, counter wrap) and a random run vs a model.
module tb_flow_sender;

  localparam int DW = 6;
  localparam int CW = 8;
`ifdef FLOW_SENDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          enb;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [1:0]    in_dest;
  logic          in_ready;
  logic [3:0]    pausa;
  logic [3:0]    continuar;
  logic          idle;
  logic          error_full;
  logic [3:0]    push;
  logic [DW-1:0] push_data;
  logic [1:0]    state_o;
  logic          halted;
  logic [4*CW-1:0] sent_cnt;

  always #5 clk = ~clk;

  flow_sender #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enb(enb),
    .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest),
    .in_ready(in_ready), .pausa(pausa), .continuar(continuar),
    .idle(idle), .error_full(error_full), .push(push),
    .push_data(push_data), .state_o(state_o), .halted(halted),
    .sent_cnt(sent_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    l;
  } word_t;

  // Reference: ordered queue of buffered words plus status flags.
  word_t      mq[$];
  logic [3:0] m_pq = '0;
  bit         m_fresh = 1'b1;
  bit         m_halt = 1'b0;
  bit         m_hold = 1'b0;
  logic [CW-1:0] m_cnt [4];

  logic [3:0]    s_push;
  logic          s_rdy;
  logic [1:0]    s_st;
  logic [3:0]    e_push;
  bit            e_rdy;
  logic [DW-1:0] plog[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic step(input bit r, input bit e, input bit v,
                      input logic [DW-1:0] vd, input logic [1:0] vl,
                      input logic [3:0] pa, input logic [3:0] co,
                      input bit id, input bit ef);
    bit            blk;
    logic [3:0]    ep;
    logic [DW-1:0] ed;
    bit            er;
    logic [1:0]    es;
    logic [4*CW-1:0] ec;
    word_t         w;
    rst = r; enb = e; in_valid = v; in_data = vd; in_dest = vl;
    pausa = pa; continuar = co; idle = id; error_full = ef;
    @(negedge clk);
    blk = 1'b0;
    if (mq.size() > 0)
      blk = m_pq[mq[0].l] && !co[mq[0].l] && !id;
    ep = '0;
    ed = '0;
    if (e && !r && !m_fresh && !m_halt && mq.size() > 0 && !blk && !ef) begin
      ep[mq[0].l] = 1'b1;
      ed = mq[0].d;
    end
    er = e && !r && !m_halt && mq.size() < 2;
    es = m_fresh ? 2'd0 : m_halt ? 2'd3 : m_hold ? 2'd2 : 2'd1;
    ec = STATS ? {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]} : '0;
    s_push = push; s_rdy = in_ready; s_st = state_o;
    e_push = ep; e_rdy = er;
    if (push != 4'b0000) plog.push_back(push_data);
    if (chk_en) begin
      check("push", 32'(push), 32'(ep));
      check("push_data", 32'(push_data), 32'(ed));
      check("in_ready", 32'(in_ready), 32'(er));
      check("state_o", 32'(state_o), 32'(es));
      check("halted", 32'(halted), 32'(m_halt));
      check("sent_cnt", 32'(sent_cnt), 32'(ec));
    end
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_pq = '0; m_fresh = 1'b1; m_halt = 1'b0; m_hold = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] = '0;
    end else if (e) begin
      if (m_fresh) begin
        m_fresh = 1'b0;
        m_halt = ef;
        m_hold = 1'b0;
      end else if (!m_halt) begin
        if (ef) begin
          m_halt = 1'b1;
          m_hold = 1'b0;
        end else begin
          m_hold = (mq.size() > 0) && blk;
        end
      end
      if (ep != 4'b0000) begin
        m_cnt[mq[0].l] = m_cnt[mq[0].l] + 1'b1;
        void'(mq.pop_front());
      end
      if (v && er) begin
        w.d = vd;
        w.l = vl;
        mq.push_back(w);
      end
      m_pq = pa;
    end
    #1;
  endtask

  typedef struct {
    bit r, e, v;
    logic [DW-1:0] d;
    logic [1:0] l;
    logic [3:0] pa, co;
    bit id, ef;
    logic [3:0] xp;
    bit xr;
    logic [1:0] xs;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit r, input bit v, input int d, input int l,
                     input logic [3:0] pa, input logic [3:0] co,
                     input bit id, input bit ef,
                     input logic [3:0] xp, input bit xr, input int xs);
    vec_t x;
    x.r = r; x.e = 1'b1; x.v = v; x.d = DW'(d); x.l = 2'(l);
    x.pa = pa; x.co = co; x.id = id; x.ef = ef;
    x.xp = xp; x.xr = xr; x.xs = 2'(xs);
    tv.push_back(x);
  endtask

  initial begin
    int k;
    int n3;
    for (int i = 0; i < 4; i++) m_cnt[i] = '0;
    // first cycle after reset falls: RESET state, already ready
    add(0, 1, 10, 0, 4'h0, 4'h0, 0, 0, 4'b0000, 1, 0);
    add(0, 1, 11, 1, 4'h0, 4'h0, 0, 0, 4'b0001, 1, 1);
    add(0, 1, 12, 2, 4'h0, 4'h0, 0, 0, 4'b0010, 1, 1);
    add(0, 1, 13, 3, 4'h0, 4'h0, 0, 0, 4'b0100, 1, 1);
    add(0, 0,  0, 0, 4'h0, 4'h0, 0, 0, 4'b1000, 1, 1);
    add(0, 0,  0, 0, 4'h0, 4'h0, 0, 0, 4'b0000, 1, 1);
    // pause lane 0 while streaming 5,6,7
    add(0, 1,  5, 0, 4'h1, 4'h0, 0, 0, 4'b0000, 1, 1);
    add(0, 1,  6, 0, 4'h1, 4'h0, 0, 0, 4'b0000, 1, 1);
    add(0, 1,  7, 0, 4'h1, 4'h0, 0, 0, 4'b0000, 0, 2);
    add(0, 1,  7, 0, 4'h0, 4'h0, 0, 0, 4'b0000, 0, 2);
    add(0, 1,  7, 0, 4'h0, 4'h0, 0, 0, 4'b0001, 0, 2);
    add(0, 1,  7, 0, 4'h0, 4'h0, 0, 0, 4'b0001, 1, 1);
    add(0, 0,  0, 0, 4'h0, 4'h0, 0, 0, 4'b0001, 1, 1);
    add(0, 0,  0, 0, 4'h0, 4'h0, 0, 0, 4'b0000, 1, 1);
    // lane 2 held, released once by continuar, once by idle
    add(0, 1, 20, 2, 4'h4, 4'h0, 0, 0, 4'b0000, 1, 1);
    add(0, 0,  0, 0, 4'h4, 4'h0, 0, 0, 4'b0000, 1, 1);
    add(0, 1, 21, 2, 4'h4, 4'h0, 0, 0, 4'b0000, 1, 2);
    add(0, 0,  0, 0, 4'h4, 4'h4, 0, 0, 4'b0100, 0, 2);
    add(0, 0,  0, 0, 4'h4, 4'h0, 0, 0, 4'b0000, 1, 1);
    add(0, 0,  0, 0, 4'h4, 4'h0, 1, 0, 4'b0100, 1, 2);
    add(0, 0,  0, 0, 4'h0, 4'h0, 0, 0, 4'b0000, 1, 1);
    // error_full against a pending push, then reset
    add(0, 1, 30, 1, 4'h0, 4'h0, 0, 0, 4'b0000, 1, 1);
    add(0, 0,  0, 0, 4'h0, 4'h0, 0, 1, 4'b0000, 1, 1);
    add(0, 1, 31, 1, 4'h0, 4'h0, 0, 0, 4'b0000, 0, 3);
    add(0, 1, 31, 1, 4'h0, 4'h0, 0, 0, 4'b0000, 0, 3);
    add(1, 0,  0, 0, 4'h0, 4'h0, 0, 0, 4'b0000, 0, 3);
    add(0, 0,  0, 0, 4'h0, 4'h0, 0, 0, 4'b0000, 1, 0);
    add(0, 0,  0, 0, 4'h0, 4'h0, 0, 0, 4'b0000, 1, 1);

    @(posedge clk);
    #1;
    step(1, 1, 0, '0, '0, '0, '0, 0, 0);
    chk_en = 1'b1;
    step(1, 1, 0, '0, '0, '0, '0, 0, 0);

    foreach (tv[i]) begin
      step(tv[i].r, tv[i].e, tv[i].v, tv[i].d, tv[i].l,
           tv[i].pa, tv[i].co, tv[i].id, tv[i].ef);
      check($sformatf("t%0d_push", i), 32'(s_push), 32'(tv[i].xp));
      check($sformatf("t%0d_rdy", i), 32'(s_rdy), 32'(tv[i].xr));
      check($sformatf("t%0d_state", i), 32'(s_st), 32'(tv[i].xs));
    end

    // enable low for three cycles mid-stream
    plog.delete();
    k = 0;
    for (int c = 0; c < 20; c++) begin
      bit e;
      e = !(c >= 3 && c < 6);
      step(0, e, k < 6, DW'(40 + k), 2'd1, '0, '0, 0, 0);
      if (!e) begin
        check("frozen_push", 32'(s_push), 32'(0));
        check("frozen_rdy", 32'(s_rdy), 32'(0));
      end
      if (k < 6 && e_rdy) k++;
    end
    check("enb_count", 32'(plog.size()), 32'(6));
    foreach (plog[i]) check($sformatf("enb_word%0d", i),
                            32'(plog[i]), 32'(40 + i));

    // 256 pushes on lane 3 wrap its counter
    step(1, 1, 0, '0, '0, '0, '0, 0, 0);
    n3 = 0;
    for (int c = 0; c < 600 && n3 < 256; c++) begin
      step(0, 1, 1, DW'(c), 2'd3, '0, '0, 0, 0);
      if (e_push[3]) begin
        n3++;
        if (n3 == 255)
          check("cnt3_255", 32'(sent_cnt[3*CW +: CW]),
                STATS ? 32'd255 : 32'd0);
      end
    end
    check("lane3_pushes", 32'(n3), 32'(256));
    check("cnt3_wrap", 32'(sent_cnt[3*CW +: CW]), 32'(0));

    // random run against the model
    step(1, 1, 0, '0, '0, '0, '0, 0, 0);
    k = 0;
    for (int c = 0; c < 3000; c++) begin
      bit r;
      k = m_halt ? k + 1 : 0;
      r = ($urandom_range(299) == 0) || (k > 12);
      step(r, $urandom_range(9) != 0, $urandom_range(3) != 0,
           DW'($urandom), 2'($urandom),
           4'($urandom & $urandom), 4'($urandom & $urandom & $urandom),
           $urandom_range(15) == 0, $urandom_range(799) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
